axis_io_fifo: RTL and testbench
===============================

Name: axis_io_fifo

Overview:
- Synchronous first-word-fall-through AXIS FIFO; one instance on each side of the MIG FIFO controller.
- Input side: buffers the user stream and presents its occupancy to the controller as the write-available count.
- Output side: absorbs controller read bursts and presents its occupancy, which the controller converts to free space.
- The controller pops and pushes per beat against the count without re-checking valid/ready, so the count must be exact. The block also flags protocol violations.

Parameters:
- DATA_WIDTH, 128: tdata width in bits; equals MIG data width × UI rate.
- DEPTH, 32: number of entries; power of two, ≥ 2; matches the controller's FIFO-depth parameter.
- ADDR_BITS, log2(DEPTH): pointer width, derived; not overridable.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_tdata  in  DATA_WIDTH  write data.
- s_tvalid  in  1  write valid.
- s_tready  out  1  write ready.
- m_tdata  out  DATA_WIDTH  read data; FWFT, valid whenever m_tvalid=1.
- m_tvalid  out  1  read valid.
- m_tready  in  1  read ready / pop.
- count  out  32  occupancy in words, 0..DEPTH, zero-extended.
- underflow_err  out  1  sticky: pop attempted while empty.
- overflow_err  out  1  sticky: push attempted while full.
- high_water  out  32  sticky maximum of count since reset/clear.
- err_clr  in  1  synchronous clear of both error flags and high_water.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, m_tvalid=0, s_tready=0, both errors=0, high_water=0. Stored data is discarded; m_tdata is don't-care. Reset mid-burst drops all contents with no partial output.
- s_tready = !areset && (count < DEPTH); combinational from registered count.
- m_tvalid = (count != 0); combinational from registered count.
- push = s_tvalid && s_tready. pop = m_tvalid && m_tready.
- Push: s_tdata is written at wr_ptr; wr_ptr increments modulo DEPTH (natural ADDR_BITS wrap).
- Pop: rd_ptr increments modulo DEPTH.
- m_tdata always shows the entry at rd_ptr. It is combinational read of the array, or an equivalent prefetch register with identical timing.
- Latency: a word pushed at edge N is visible on m_tdata with m_tvalid=1 after edge N (1 cycle), and count includes it after the same edge N.
- Count update per edge:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; both pointers advance.
  - neither: unchanged.
- Push and pop when count=1: the old word pops and the new word is stored; m_tvalid stays 1 and m_tdata shows the new word next cycle.
- Full (count=DEPTH): s_tready=0, so no push occurs even if pop=1 that cycle. Ready returns the cycle after a pop.
- Empty (count=0): m_tvalid=0. If m_tready=1, no pop occurs, pointers and count hold, and underflow_err is set on that edge.
- s_tvalid=1 while count=DEPTH: data is not written and overflow_err is set on that edge. A held tvalid during backpressure is legal AXIS, so the monitor counts this as a push attempt only when s_tready=0 and count=DEPTH.
- Error flags stay set until err_clr=1 or reset.
- high_water: updated each edge to max(high_water, next count).
- err_clr: clears errors and high_water on that edge. If an error event coincides with err_clr, the event wins (flag set). high_water after clear = next count.
- count is never negative and never exceeds DEPTH. Any other value is a design bug; the bench asserts this.
- No combinational path from s_tvalid to s_tready or from m_tready to m_tvalid.

Test Plan:
- Reset then fill: DEPTH=32, push 32 words 0..31 back-to-back with m_tready=0 → count=32, s_tready=0 after the 32nd edge, high_water=32, no errors.
- Drain: after the fill, m_tready=1 for 32 cycles → m_tdata sequence 0..31 in order, count reaches 0, m_tvalid=0, s_tready=1.
- Steady stream with count=1: push and pop every cycle for 100 cycles → count stays 1, output sequence equals input delayed one word, no errors.
- Wrap-around: push 20, pop 20, push 30, pop 30 (pointers cross index 31→0) → all 50 words returned in order, high_water=30.
- Underflow: count=0, m_tready=1 for 1 cycle → underflow_err=1, count=0, pointers unchanged. Then err_clr=1 → underflow_err=0.
- Overflow and reset mid-burst: fill to 32, hold s_tvalid=1 → overflow_err=1, word not stored. Assert areset at count=17 → immediately count=0, m_tvalid=0, s_tready=0, flags=0. After release, s_tready=1.

Source files
------------

// File: rtl/axis_io_fifo.sv
// First-word-fall-through AXI-Stream FIFO with an exact occupancy count,
// sticky protocol-violation flags and a high-water mark.
module axis_io_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           count,
  output logic                  underflow_err,
  output logic                  overflow_err,
  output logic [31:0]           high_water,
  input  logic                  err_clr
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  typedef logic [ADDR_BITS-1:0] ptr_t;
  typedef logic [ADDR_BITS:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t hw_q, hw_d;
  logic uf_q, uf_d;
  logic of_q, of_d;
  logic push, pop;

  // Handshake outputs depend only on registered count, never on the partner's valid/ready.
  assign s_tready = !areset && (count_q < CNT_FULL);
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];

  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    uf_d     = uf_q;
    of_d     = of_q;
    hw_d     = hw_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A violation on the same edge as err_clr must still be recorded.
    if (err_clr) begin
      uf_d = 1'b0;
      of_d = 1'b0;
    end
    if (m_tready && (count_q == '0))                      uf_d = 1'b1;
    if (s_tvalid && !s_tready && (count_q == CNT_FULL))   of_d = 1'b1;

    if (err_clr)              hw_d = count_d;
    else if (count_d > hw_q)  hw_d = count_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
      hw_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
      hw_q     <= hw_d;
    end
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata;
  end

  assign count         = 32'(count_q);
  assign high_water    = 32'(hw_q);
  assign underflow_err = uf_q;
  assign overflow_err  = of_q;

endmodule

// File: tb/tb_axis_io_fifo.sv
// Scoreboard bench for axis_io_fifo: a behavioural occupancy/flag model plus
// a queue of expected words, checked scenario by scenario.
module tb_axis_io_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [31:0]   count;
  logic          underflow_err;
  logic          overflow_err;
  logic [31:0]   high_water;
  logic          err_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sb[$];
  int   mcnt = 0;
  int   mhw = 0;
  logic muf = 1'b0;
  logic mof = 1'b0;

  logic          last_popped;
  logic [DW-1:0] last_got;
  logic [DW-1:0] last_exp;

  axis_io_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .count(count), .underflow_err(underflow_err), .overflow_err(overflow_err),
    .high_water(high_water), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (!areset && count > DEPTH) begin
      miscompares++;
      $display("FAIL count_range: count=%0d exceeds depth %0d", count, DEPTH);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    mcnt = 0; mhw = 0; muf = 1'b0; mof = 1'b0;
    sb.delete();
  endfunction

  // One clock: drive inputs, sample output before the edge, advance the model.
  task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic clr);
    logic p, q, uf_ev, of_ev;
    s_tvalid = sv; s_tdata = sd; m_tready = mr; err_clr = clr;
    p     = sv && (mcnt < DEPTH);
    q     = mr && (mcnt > 0);
    uf_ev = mr && (mcnt == 0);
    of_ev = sv && (mcnt == DEPTH);
    @(negedge aclk);
    last_popped = q;
    last_got    = m_tdata;
    last_exp    = '0;
    if (q) last_exp = sb.pop_front();
    if (p) sb.push_back(sd);
    @(posedge aclk);
    #1;
    mcnt = mcnt + (p ? 1 : 0) - (q ? 1 : 0);
    if (clr) begin muf = 1'b0; mof = 1'b0; end
    if (uf_ev) muf = 1'b1;
    if (of_ev) mof = 1'b1;
    if (clr) mhw = mcnt;
    else if (mcnt > mhw) mhw = mcnt;
    s_tvalid = 1'b0; m_tready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 areset = 1'b1;
    #1;
    vectors++;
    if (count !== 32'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d m_tvalid=%b s_tready=%b, want 0/0/0", count, m_tvalid, s_tready);
    end
    vectors++;
    if (underflow_err !== 1'b0 || overflow_err !== 1'b0 || high_water !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_flags: uf=%b of=%b hw=%0d, want 0/0/0", underflow_err, overflow_err, high_water);
    end
    @(negedge aclk) areset = 1'b0;
    @(posedge aclk); #1;
    model_reset();
    vectors++;
    if (s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: s_tready=%b want 1", s_tready);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    vectors++;
    if (count !== 32'(DEPTH) || s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: count=%0d s_tready=%b m_tvalid=%b, want %0d/0/1", count, s_tready, m_tvalid, DEPTH);
    end
    vectors++;
    if (high_water !== 32'(mhw) || underflow_err !== muf || overflow_err !== mof) begin
      miscompares++;
      $display("FAIL fill_flags: hw=%0d uf=%b of=%b, want %0d/%b/%b", high_water, underflow_err, overflow_err, mhw, muf, mof);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (!last_popped || last_got !== last_exp) begin
        miscompares++;
        $display("FAIL drain_data[%0d]: got %h want %h", i, last_got, last_exp);
      end
    end
    vectors++;
    if (count !== 32'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: count=%0d m_tvalid=%b s_tready=%b, want 0/0/1", count, m_tvalid, s_tready);
    end
    vectors++;
    if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_flags: uf=%b of=%b want 0/0", underflow_err, overflow_err);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, rnd_word(), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, rnd_word(), 1'b1, 1'b0);
      vectors++;
      if (!last_popped || last_got !== last_exp || count !== 32'd1 || m_tvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream[%0d]: got %h want %h count=%0d m_tvalid=%b", i, last_got, last_exp, count, m_tvalid);
      end
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (last_got !== last_exp || count !== 32'd0 || underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_tail: got %h want %h count=%0d uf=%b of=%b", last_got, last_exp, count, underflow_err, overflow_err);
    end
  endtask

  task automatic test_wrap();
    int bursts[4] = '{20, 20, 30, 30};
    tick(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (high_water !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_hw_clear: hw=%0d want 0", high_water);
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < bursts[b]; i++) begin
        if (b % 2 == 0) tick(1'b1, rnd_word(), 1'b0, 1'b0);
        else begin
          tick(1'b0, '0, 1'b1, 1'b0);
          vectors++;
          if (!last_popped || last_got !== last_exp) begin
            miscompares++;
            $display("FAIL wrap_data[%0d.%0d]: got %h want %h", b, i, last_got, last_exp);
          end
        end
      end
    end
    vectors++;
    if (high_water !== 32'd30 || count !== 32'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_end: hw=%0d count=%0d left=%0d, want 30/0/0", high_water, count, sb.size());
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] w;
    tick(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (underflow_err !== 1'b1 || count !== 32'd0 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_set: uf=%b count=%0d m_tvalid=%b, want 1/0/0", underflow_err, count, m_tvalid);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    vectors++;
    if (underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: uf=%b want 0", underflow_err);
    end
    tick(1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if (underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_vs_clear: uf=%b want 1", underflow_err);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    w = rnd_word();
    tick(1'b1, w, 1'b0, 1'b0);
    vectors++;
    if (m_tdata !== w || count !== 32'd1 || high_water !== 32'd1) begin
      miscompares++;
      $display("FAIL underflow_ptrs: m_tdata=%h want %h count=%0d hw=%0d", m_tdata, w, count, high_water);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (last_got !== last_exp || count !== 32'd0) begin
      miscompares++;
      $display("FAIL underflow_tail: got %h want %h count=%0d", last_got, last_exp, count);
    end
  endtask

  task automatic test_overflow_reset();
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, rnd_word(), 1'b0, 1'b0);
    tick(1'b1, rnd_word(), 1'b0, 1'b0);
    vectors++;
    if (overflow_err !== 1'b1 || count !== 32'(DEPTH) || s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_set: of=%b count=%0d s_tready=%b, want 1/%0d/0", overflow_err, count, s_tready, DEPTH);
    end
    tick(1'b1, rnd_word(), 1'b1, 1'b0);
    vectors++;
    if (last_got !== last_exp || count !== 32'(DEPTH - 1) || s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop: got %h want %h count=%0d s_tready=%b", last_got, last_exp, count, s_tready);
    end
    while (mcnt > 17) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (last_got !== last_exp) begin
        miscompares++;
        $display("FAIL overflow_drain: got %h want %h", last_got, last_exp);
      end
    end
    vectors++;
    if (count !== 32'd17 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: count=%0d of=%b want 17/1", count, overflow_err);
    end
    #2 areset = 1'b1;
    #1;
    vectors++;
    if (count !== 32'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0 || high_water !== 32'd0) begin
      miscompares++;
      $display("FAIL midburst_reset: count=%0d m_tvalid=%b s_tready=%b of=%b uf=%b hw=%0d",
               count, m_tvalid, s_tready, overflow_err, underflow_err, high_water);
    end
    @(negedge aclk) areset = 1'b0;
    @(posedge aclk); #1;
    model_reset();
    vectors++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_ready: s_tready=%b m_tvalid=%b want 1/0", s_tready, m_tvalid);
    end
    w = rnd_word();
    tick(1'b1, w, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (last_got !== w || last_exp !== w || count !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_word: got %h want %h count=%0d", last_got, w, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_underflow();
    test_overflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
